// File: rtl/reg_wb_sched_if.sv
// Issue, writeback and register-file signals of the writeback scheduler.
// The scheduler takes the slave side; the environment driving it takes the master side.
interface reg_wb_sched_if #(parameter int XLEN = 32);
   logic            iss_valid;
   logic            iss_ready;
   logic [4:0]      iss_rs1;
   logic [4:0]      iss_rs2;
   logic [4:0]      iss_rd;
   logic            iss_rs1_en;
   logic            iss_rs2_en;
   logic            iss_rd_en;

   logic            alu_valid;
   logic            alu_ready;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            lsu_valid;
   logic            lsu_ready;
   logic [4:0]      lsu_rd;
   logic [XLEN-1:0] lsu_data;

   logic            rf_we;
   logic [4:0]      rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic [31:0]     busy;
   logic            wb_err;

   modport slave (
      input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rs1_en, iss_rs2_en, iss_rd_en,
      input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
      output iss_ready, alu_ready, lsu_ready,
      output rf_we, rf_waddr, rf_wdata, busy, wb_err
   );

   modport master (
      output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rs1_en, iss_rs2_en, iss_rd_en,
      output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
      input  iss_ready, alu_ready, lsu_ready,
      input  rf_we, rf_waddr, rf_wdata, busy, wb_err
   );
endinterface

// File: rtl/reg_wb_sched.sv
// Register scoreboard with RAW/WAW issue stall and round-robin ALU/LSU writeback
// arbitration into a registered register-file write port.
module reg_wb_sched #(
   parameter int XLEN = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   reg_wb_sched_if.slave  bus
);

   logic [31:0]     busy_q, busy_d;
   logic            rf_we_q, rf_we_d;
   logic [4:0]      rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
   logic            wb_err_q, wb_err_d;
   logic            prio_alu_q, prio_alu_d;

   logic            hazard;
   logic            iss_fire;
   logic            gnt_alu, gnt_lsu, gnt_any;
   logic [4:0]      gnt_rd;
   logic [XLEN-1:0] gnt_data;
   logic [31:0]     set_mask, clr_mask;

   always_comb begin
      hazard = (bus.iss_rs1_en & busy_q[bus.iss_rs1])
             | (bus.iss_rs2_en & busy_q[bus.iss_rs2])
             | (bus.iss_rd_en  & busy_q[bus.iss_rd]);
      iss_fire = bus.iss_valid & rst_n & ~hazard;

      // Contention goes to whichever unit did not win last; a lone requester always wins.
      gnt_alu = rst_n & bus.alu_valid & (~bus.lsu_valid | prio_alu_q);
      gnt_lsu = rst_n & bus.lsu_valid & (~bus.alu_valid | ~prio_alu_q);
      gnt_any = gnt_alu | gnt_lsu;
      gnt_rd   = gnt_alu ? bus.alu_rd   : bus.lsu_rd;
      gnt_data = gnt_alu ? bus.alu_data : bus.lsu_data;
   end

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (iss_fire && bus.iss_rd_en) set_mask[bus.iss_rd] = 1'b1;
      // The scoreboard entry drops on the same edge that the register file commits.
      if (rf_we_q) clr_mask[rf_waddr_q] = 1'b1;
      busy_d    = (busy_q & ~clr_mask) | set_mask;
      busy_d[0] = 1'b0;

      rf_we_d    = gnt_any && (gnt_rd != 5'd0);
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (rf_we_d) begin
         rf_waddr_d = gnt_rd;
         rf_wdata_d = gnt_data;
      end

      wb_err_d = wb_err_q | (rf_we_d & ~busy_q[gnt_rd]);

      prio_alu_d = prio_alu_q;
      if (gnt_any) prio_alu_d = gnt_lsu;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q     <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         wb_err_q   <= 1'b0;
         prio_alu_q <= 1'b1;
      end else begin
         busy_q     <= busy_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         wb_err_q   <= wb_err_d;
         prio_alu_q <= prio_alu_d;
      end
   end

   assign bus.iss_ready = rst_n & ~hazard;
   assign bus.alu_ready = gnt_alu;
   assign bus.lsu_ready = gnt_lsu;
   assign bus.rf_we     = rf_we_q;
   assign bus.rf_waddr  = rf_waddr_q;
   assign bus.rf_wdata  = rf_wdata_q;
   assign bus.busy      = busy_q;
   assign bus.wb_err    = wb_err_q;

endmodule

// File: tb/tb_reg_wb_sched.sv
// Directed checks of the scoreboard stall, writeback arbitration, rd=0 handling,
// error flag and reset behaviour of reg_wb_sched.
module tb_reg_wb_sched;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;

   reg_wb_sched_if #(.XLEN(32)) bus ();

   reg_wb_sched #(.XLEN(32)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.iss_valid  = 1'b0;
      bus.iss_rs1    = '0;
      bus.iss_rs2    = '0;
      bus.iss_rd     = '0;
      bus.iss_rs1_en = 1'b0;
      bus.iss_rs2_en = 1'b0;
      bus.iss_rd_en  = 1'b0;
      bus.alu_valid  = 1'b0;
      bus.alu_rd     = '0;
      bus.alu_data   = '0;
      bus.lsu_valid  = 1'b0;
      bus.lsu_rd     = '0;
      bus.lsu_data   = '0;
   endtask

   task automatic issue_rd(input logic [4:0] rd);
      bus.iss_valid = 1'b1;
      bus.iss_rd_en = 1'b1;
      bus.iss_rd    = rd;
   endtask

   task automatic all_ops(input logic [4:0] r);
      bus.iss_rs1 = r;  bus.iss_rs2 = r;  bus.iss_rd = r;
      bus.iss_rs1_en = 1'b1;  bus.iss_rs2_en = 1'b1;  bus.iss_rd_en = 1'b1;
   endtask

   initial begin
      // Reset with requests present: every ready must stay low.
      idle();
      all_ops(5'd5);
      bus.iss_valid = 1'b1;
      bus.alu_valid = 1'b1;
      bus.lsu_valid = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_iss_ready", bus.iss_ready, 0);
      chk("rst_alu_ready", bus.alu_ready, 0);
      chk("rst_lsu_ready", bus.lsu_ready, 0);
      chk("rst_rf_we",     bus.rf_we, 0);
      chk("rst_rf_waddr",  bus.rf_waddr, 0);
      chk("rst_rf_wdata",  bus.rf_wdata, 0);
      chk("rst_busy",      bus.busy, 0);
      chk("rst_wb_err",    bus.wb_err, 0);
      idle();
      all_ops(5'd5);
      rst_n = 1'b1;
      #1;
      chk("post_rst_iss_ready", bus.iss_ready, 1);
      idle();

      // RAW stall on x5, ALU writeback, release two cycles after grant.
      tick(); issue_rd(5'd5); #1;
      chk("raw_iss0_ready", bus.iss_ready, 1);
      tick(); idle(); bus.iss_rs1_en = 1'b1; bus.iss_rs1 = 5'd5; #1;
      chk("raw_c1_ready", bus.iss_ready, 0);
      chk("raw_c1_busy",  bus.busy, 32'h20);
      tick(); #1;
      tick(); bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF; #1;
      chk("raw_c3_alu_ready", bus.alu_ready, 1);
      chk("raw_c3_lsu_ready", bus.lsu_ready, 0);
      tick(); bus.alu_valid = 1'b0; #1;
      chk("raw_c4_rf_we",     bus.rf_we, 1);
      chk("raw_c4_rf_waddr",  bus.rf_waddr, 5);
      chk("raw_c4_rf_wdata",  bus.rf_wdata, 32'hDEADBEEF);
      chk("raw_c4_ready",     bus.iss_ready, 0);
      tick(); #1;
      chk("raw_c5_rf_we",     bus.rf_we, 0);
      chk("raw_c5_rf_waddr",  bus.rf_waddr, 5);
      chk("raw_c5_busy",      bus.busy, 0);
      chk("raw_c5_ready",     bus.iss_ready, 1);
      chk("raw_c5_wb_err",    bus.wb_err, 0);
      idle();

      // rd=0 on issue and on writeback touches nothing.
      tick(); issue_rd(5'd0); #1;
      chk("x0_iss_ready", bus.iss_ready, 1);
      tick(); idle(); bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'h1234; #1;
      chk("x0_busy",      bus.busy, 0);
      chk("x0_lsu_ready", bus.lsu_ready, 1);
      chk("x0_alu_ready", bus.alu_ready, 0);
      tick(); idle(); #1;
      chk("x0_rf_we",     bus.rf_we, 0);
      chk("x0_wb_err",    bus.wb_err, 0);
      chk("x0_busy2",     bus.busy, 0);

      // Both units requesting continuously: strict alternation starting with ALU.
      tick(); issue_rd(5'd1); #1;
      chk("rr_iss1_ready", bus.iss_ready, 1);
      tick(); issue_rd(5'd2); #1;
      chk("rr_iss2_ready", bus.iss_ready, 1);
      tick(); idle();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h11;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd2; bus.lsu_data = 32'h22;
      for (int k = 0; k < 5; k++) begin
         if (k == 4) begin bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0; end
         #1;
         if (k == 0) chk("rr_busy", bus.busy, 32'h6);
         if (k < 4) begin
            chk($sformatf("rr_alu_ready_%0d", k), bus.alu_ready, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("rr_lsu_ready_%0d", k), bus.lsu_ready, (k % 2 == 1) ? 1 : 0);
         end
         if (k > 0) begin
            chk($sformatf("rr_rf_we_%0d", k),    bus.rf_we, 1);
            chk($sformatf("rr_rf_waddr_%0d", k), bus.rf_waddr, ((k - 1) % 2 == 0) ? 1 : 2);
            chk($sformatf("rr_rf_wdata_%0d", k), bus.rf_wdata, ((k - 1) % 2 == 0) ? 32'h11 : 32'h22);
         end
         tick();
      end
      #1;
      chk("rr_wb_err", bus.wb_err, 1);

      // Reset one cycle after a grant discards the pending write.
      issue_rd(5'd9); #1;
      chk("mid_iss_ready", bus.iss_ready, 1);
      tick(); idle(); bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99; #1;
      chk("mid_alu_ready", bus.alu_ready, 1);
      tick(); idle(); all_ops(5'd9); rst_n = 1'b0; #1;
      chk("mid_rst_rf_we",     bus.rf_we, 0);
      chk("mid_rst_busy",      bus.busy, 0);
      chk("mid_rst_wb_err",    bus.wb_err, 0);
      chk("mid_rst_iss_ready", bus.iss_ready, 0);
      tick(); #1;
      chk("mid_rst_rf_we2", bus.rf_we, 0);
      rst_n = 1'b1; #1;
      chk("mid_rel_iss_ready", bus.iss_ready, 1);
      tick(); #1;
      chk("mid_rel_rf_we", bus.rf_we, 0);
      chk("mid_rel_busy",  bus.busy, 0);
      idle();

      // Writeback to a register that was never issued sets the sticky error.
      tick(); bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h77; #1;
      chk("err_lsu_ready", bus.lsu_ready, 1);
      chk("err_wb_err0",   bus.wb_err, 0);
      tick(); idle(); #1;
      chk("err_rf_we",     bus.rf_we, 1);
      chk("err_rf_waddr",  bus.rf_waddr, 7);
      chk("err_rf_wdata",  bus.rf_wdata, 32'h77);
      chk("err_wb_err1",   bus.wb_err, 1);
      repeat (3) tick();
      #1;
      chk("err_sticky",    bus.wb_err, 1);
      chk("err_rf_we_off", bus.rf_we, 0);

      // WAW on x3 holds the second issue until the cycle after commit.
      tick(); issue_rd(5'd3); #1;
      chk("waw_iss0_ready", bus.iss_ready, 1);
      tick(); #1;
      chk("waw_c1_ready", bus.iss_ready, 0);
      tick(); bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h33; #1;
      chk("waw_c2_ready",     bus.iss_ready, 0);
      chk("waw_c2_alu_ready", bus.alu_ready, 1);
      tick(); bus.alu_valid = 1'b0; #1;
      chk("waw_c3_rf_we",  bus.rf_we, 1);
      chk("waw_c3_waddr",  bus.rf_waddr, 3);
      chk("waw_c3_ready",  bus.iss_ready, 0);
      tick(); #1;
      chk("waw_c4_ready",  bus.iss_ready, 1);
      tick(); idle(); #1;
      chk("waw_c5_busy",   bus.busy, 32'h8);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/reg_wb_sched.md
REG_WB_SCHED -- requirements
Module: reg_wb_sched

Interface
REQ-001 Parameter: XLEN, 32, data width of register file write port and writeback data.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 iss_valid  in  1  issue slot presents an instruction.
REQ-005 iss_ready  out  1  instruction may issue this cycle (no hazard).
REQ-006 iss_rs1, iss_rs2, iss_rd  in  5 each  source/destination register indices.
REQ-007 iss_rs1_en, iss_rs2_en, iss_rd_en  in  1 each  operand/destination used.
REQ-008 alu_valid / lsu_valid  in  1 each  writeback request from ALU / load unit.
REQ-009 alu_ready / lsu_ready  out  1 each  writeback request accepted this cycle.
REQ-010 alu_rd / lsu_rd  in  5 each  writeback destination index.
REQ-011 alu_data / lsu_data  in  XLEN each  writeback value.
REQ-012 rf_we  out  1  register file write enable (registered).
REQ-013 rf_waddr  out  5  register file write address (registered).
REQ-014 rf_wdata  out  XLEN  register file write data (registered).
REQ-015 busy  out  32  scoreboard vector, bit i = write to xi pending.
REQ-016 wb_err  out  1  sticky: writeback to a non-busy nonzero register occurred.

Function
REQ-017 Scoreboard busy[31:0]; busy[0] SHALL be constant 0.
REQ-018 Hazard = (rs1_en & busy[rs1]) | (rs2_en & busy[rs2]) | (rd_en & busy[rd]) (RAW and WAW).
REQ-019 iss_ready = !hazard, combinational, may depend on iss_* inputs; forced 0 while rst_n low.
REQ-020 Issue fire = iss_valid & iss_ready; on fire with rd_en & rd!=0, busy[rd] set at that edge.
REQ-021 Issue with rd_en & rd==0: fires normally, no scoreboard change.
REQ-022 Writeback arbitration: round-robin between ALU and LSU; single requester granted immediately.
REQ-023 Both valid: grant the one not granted last; pointer after reset favours ALU.
REQ-024 Grant is combinational; alu_ready/lsu_ready = grant, at most one high per cycle; forced 0 during reset.
REQ-025 Requester holds valid, rd, data stable until its ready; a waiting requester SHALL be granted within 2 cycles.
REQ-026 Grant in cycle N -> rf_we=1, rf_waddr=rd, rf_wdata=data in cycle N+1; register file commits at end of N+1.
REQ-027 busy[rd] SHALL clear at the edge ending cycle N+1 (same edge as commit); dependent instruction earliest iss_ready in cycle N+2; no bypass.
REQ-028 Grant with rd==0: request consumed, rf_we stays 0 in N+1, no busy change.
REQ-029 Granted rd!=0 with busy[rd]==0 at grant: write still performed, wb_err set and held until reset.
REQ-030 Issue fire setting busy[X] in same cycle a commit clears busy[X] cannot occur (WAW blocks issue); set and clear of different bits in one cycle both take effect.
REQ-031 No grant in cycle N -> rf_we=0 in N+1; rf_waddr/rf_wdata hold previous values.

Reset
REQ-032 rst_n low: busy=0, rf_we=0, rf_waddr=0, rf_wdata=0, wb_err=0, RR pointer = ALU-first, all ready outputs 0.
REQ-033 Reset mid-operation discards pending scoreboard entries and any registered write; no rf_we pulse after release until a new grant.
REQ-034 First cycle after rst_n rises: iss_ready=1 for any operands (all clear).

Verification
REQ-035 Issue rd=5 in cycle 0; cycle 1 issue rs1=5 -> iss_ready=0; ALU wb rd=5 data=0xDEADBEEF granted cycle 3 -> rf_we/rf_waddr=5/0xDEADBEEF in 4, busy[5]=0 in 5, iss_ready=1 in 5.
REQ-036 ALU and LSU valid continuously with rd=1,2 (both busy) -> grants alternate ALU,LSU,ALU,...; rf_waddr sequence 1,2,1,...; neither waits >2 cycles.
REQ-037 Issue rd=0 then LSU wb rd=0 -> busy stays 0, lsu_ready=1, rf_we never asserted, wb_err=0.
REQ-038 LSU wb rd=7 with busy[7]=0 -> rf_we=1 addr 7 next cycle, wb_err=1 and remains 1 until reset.
REQ-039 Issue rd=3 (WAW) while busy[3]=1 -> iss_ready=0 until cycle after commit of x3.
REQ-040 Assert rst_n low one cycle after a grant -> rf_we=0 throughout, busy=0, after release iss_ready=1.
